// File: rtl/state_mac_path_driver_if.sv
// Handshake bundle between the path driver and whoever requests runs.
// The DUT side uses the slave modport; the requester (and i_sta feedback source) uses master.
interface state_mac_path_driver_if;
  logic       i_start;
  logic [2:0] i_target;
  logic [2:0] i_sta;
  logic       o_x;
  logic       o_y;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
  logic [3:0] o_steps;

  modport master (
    output i_start, i_target, i_sta,
    input  o_x, o_y, o_busy, o_done, o_err, o_steps
  );

  modport slave (
    input  i_start, i_target, i_sta,
    output o_x, o_y, o_busy, o_done, o_err, o_steps
  );
endinterface

// File: rtl/state_mac_path_driver.sv
// Walks the 8-state x/y controller to a requested target along the shortest path,
// issuing one registered x/y pulse per hop and checking the controller's reply.
module state_mac_path_driver #(
  parameter int MAX_STEPS = 7
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  state_mac_path_driver_if.slave        bus
);

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [2:0] ST_F = 3'd5;
  localparam logic [2:0] ST_G = 3'd6;
  localparam logic [2:0] ST_H = 3'd7;
  localparam logic [3:0] MAX_STEPS_W = 4'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, DRIVE, CHECK, DONE, ERR} state_t;

  state_t     state_q, state_d;
  logic       x_q, x_d;
  logic       y_q, y_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] steps_q, steps_d;
  logic [2:0] target_q, target_d;
  logic [2:0] expected_q, expected_d;
  logic [1:0] hop;

  // Controller transition table; unlisted input combinations hold.
  function automatic logic [2:0] model_next(input logic [2:0] cur, input logic [1:0] xy);
    logic x;
    logic y;
    x = xy[1];
    y = xy[0];
    model_next = cur;
    case (cur)
      ST_A: if (x) model_next = ST_B; else if (y) model_next = ST_E;
      ST_B: if (x) model_next = ST_D;
      ST_C: if (x) model_next = ST_A; else if (y) model_next = ST_G;
      ST_D: if (x) model_next = ST_C;
      ST_E: if (x | y) model_next = ST_F;
      ST_F: if (x | y) model_next = ST_B;
      ST_G: if (x | y) model_next = ST_H;
      ST_H: if (x | y) model_next = ST_D;
      default: model_next = cur;
    endcase
  endfunction

  // Only A and C branch; the y branch wins when it leads into the target's side of the ring.
  function automatic logic [1:0] hop_sel(input logic [2:0] cur, input logic [2:0] tgt);
    if (cur == ST_A && (tgt == ST_E || tgt == ST_F))
      hop_sel = 2'b01;
    else if (cur == ST_C && (tgt == ST_G || tgt == ST_H))
      hop_sel = 2'b01;
    else
      hop_sel = 2'b10;
  endfunction

  always_comb begin
    state_d    = state_q;
    x_d        = 1'b0;
    y_d        = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    steps_d    = steps_q;
    target_d   = target_q;
    expected_d = expected_q;
    hop        = 2'b00;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.i_start) begin
          target_d = bus.i_target;
          done_d   = 1'b0;
          err_d    = 1'b0;
          steps_d  = 4'd0;
          if (bus.i_sta == bus.i_target) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            hop        = hop_sel(bus.i_sta, bus.i_target);
            {x_d, y_d} = hop;
            expected_d = model_next(bus.i_sta, hop);
            steps_d    = 4'd1;
            state_d    = DRIVE;
          end
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (bus.i_sta != expected_q) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else if (bus.i_sta == target_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (steps_q == MAX_STEPS_W) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          hop        = hop_sel(bus.i_sta, target_q);
          {x_d, y_d} = hop;
          expected_d = model_next(bus.i_sta, hop);
          steps_d    = steps_q + 4'd1;
          state_d    = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output register stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= 4'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
      err_q   <= err_d;
      steps_q <= steps_d;
    end
  end

  // Run data; only read after being loaded by an accepted start
  always_ff @(posedge i_clk) begin
    target_q   <= target_d;
    expected_q <= expected_d;
  end

  assign bus.o_x     = x_q;
  assign bus.o_y     = y_q;
  assign bus.o_busy  = (state_q == DRIVE) || (state_q == CHECK);
  assign bus.o_done  = done_q;
  assign bus.o_err   = err_q;
  assign bus.o_steps = steps_q;

endmodule

// File: tb/tb_state_mac_path_driver.sv
// Directed bench: two drivers (MAX_STEPS 7 and 2), each beside a behavioural x/y controller.
module tb_state_mac_path_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  state_mac_path_driver_if ifa ();
  state_mac_path_driver_if ifb ();

  state_mac_path_driver #(.MAX_STEPS(7)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  state_mac_path_driver #(.MAX_STEPS(2)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  int pass_n = 0;
  int chk_n  = 0;

  logic [2:0] sta_a, sta_b, ld_val_a, ld_val_b;
  logic       ld_a = 1'b0, ld_b = 1'b0, hold_a = 1'b0;

  function automatic logic [2:0] ctrl_next(input logic [2:0] s, input logic x, input logic y);
    case (s)
      3'd0:    return x ? 3'd1 : (y ? 3'd4 : 3'd0);
      3'd1:    return x ? 3'd3 : 3'd1;
      3'd2:    return x ? 3'd0 : (y ? 3'd6 : 3'd2);
      3'd3:    return x ? 3'd2 : 3'd3;
      3'd4:    return (x | y) ? 3'd5 : 3'd4;
      3'd5:    return (x | y) ? 3'd1 : 3'd5;
      3'd6:    return (x | y) ? 3'd7 : 3'd6;
      default: return (x | y) ? 3'd3 : 3'd7;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ld_a) sta_a <= ld_val_a;
    else if (!hold_a) sta_a <= ctrl_next(sta_a, ifa.o_x, ifa.o_y);
    if (ld_b) sta_b <= ld_val_b;
    else sta_b <= ctrl_next(sta_b, ifb.o_x, ifb.o_y);
  end

  assign ifa.i_sta = sta_a;
  assign ifb.i_sta = sta_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [2:0] s);
    ld_val_a = s; ld_a = 1'b1; tick(); ld_a = 1'b0;
  endtask

  task automatic load_b(input logic [2:0] s);
    ld_val_b = s; ld_b = 1'b1; tick(); ld_b = 1'b0;
  endtask

  // Start a run on dut_a and record hop pattern, hop count and the first cycle done/err is seen.
  task automatic go(input logic [2:0] tgt, input int ncyc, output logic [11:0] seq,
                    output int nh, output int kend);
    seq = '0; nh = 0; kend = -1;
    ifa.i_target = tgt; ifa.i_start = 1'b1; tick(); ifa.i_start = 1'b0;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) tick();
      if (ifa.o_x | ifa.o_y) begin seq = {seq[9:0], ifa.o_x, ifa.o_y}; nh++; end
      if (kend < 0 && (ifa.o_done | ifa.o_err)) kend = k;
    end
  endtask

  task automatic test_reset();
    ifa.i_start = 1'b0; ifa.i_target = 3'd0;
    ifb.i_start = 1'b0; ifb.i_target = 3'd0;
    #3;
    chk_n++; if ({ifa.o_x, ifa.o_y, ifa.o_busy, ifa.o_done, ifa.o_err} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {ifa.o_x, ifa.o_y, ifa.o_busy, ifa.o_done, ifa.o_err}); else pass_n++;
    chk_n++; if (ifa.o_steps !== 4'd0) $display("FAIL reset_steps got %0d want 0", ifa.o_steps); else pass_n++;
    @(negedge clk); rst_n = 1'b1;
    load_a(3'd0);
    tick();
    chk_n++; if ({ifa.o_busy, ifa.o_done, ifa.o_x} !== 3'b0) $display("FAIL idle_after_reset got %b want 000", {ifa.o_busy, ifa.o_done, ifa.o_x}); else pass_n++;
  endtask

  task automatic test_a_to_c();
    logic [11:0] seq; int nh, kend;
    load_a(3'd0);
    go(3'd2, 9, seq, nh, kend);
    chk_n++; if (seq[5:0] !== 6'b101010 || nh != 3) $display("FAIL a_to_c_hops got %b/%0d want 101010/3", seq[5:0], nh); else pass_n++;
    chk_n++; if (kend != 6) $display("FAIL a_to_c_time got %0d want 6", kend); else pass_n++;
    chk_n++; if ({ifa.o_done, ifa.o_err, ifa.o_busy} !== 3'b100) $display("FAIL a_to_c_held got %b want 100", {ifa.o_done, ifa.o_err, ifa.o_busy}); else pass_n++;
    chk_n++; if (ifa.o_steps !== 4'd3 || sta_a !== 3'd2) $display("FAIL a_to_c_end got steps %0d sta %0d want 3 2", ifa.o_steps, sta_a); else pass_n++;
  endtask

  task automatic test_a_to_f();
    logic [11:0] seq; int nh, kend;
    load_a(3'd0);
    chk_n++; if (ifa.o_done !== 1'b1) $display("FAIL done_hold_pre got %b want 1", ifa.o_done); else pass_n++;
    go(3'd5, 6, seq, nh, kend);
    chk_n++; if (seq[3:0] !== 4'b0110 || nh != 2) $display("FAIL a_to_f_hops got %b/%0d want 0110/2", seq[3:0], nh); else pass_n++;
    chk_n++; if (kend != 4 || ifa.o_steps !== 4'd2 || sta_a !== 3'd5) $display("FAIL a_to_f_end got t%0d s%0d sta%0d want t4 s2 sta5", kend, ifa.o_steps, sta_a); else pass_n++;
  endtask

  task automatic test_from_c();
    logic [11:0] seq; int nh, kend;
    load_a(3'd2);
    go(3'd7, 6, seq, nh, kend);
    chk_n++; if (seq[3:0] !== 4'b0110 || kend != 4 || ifa.o_done !== 1'b1) $display("FAIL c_to_h got %b t%0d d%b want 0110 t4 d1", seq[3:0], kend, ifa.o_done); else pass_n++;
    chk_n++; if (ifa.o_steps !== 4'd2 || sta_a !== 3'd7) $display("FAIL c_to_h_end got s%0d sta%0d want s2 sta7", ifa.o_steps, sta_a); else pass_n++;
    load_a(3'd2);
    go(3'd1, 6, seq, nh, kend);
    chk_n++; if (seq[3:0] !== 4'b1010 || kend != 4 || ifa.o_done !== 1'b1) $display("FAIL c_to_b got %b t%0d d%b want 1010 t4 d1", seq[3:0], kend, ifa.o_done); else pass_n++;
    chk_n++; if (ifa.o_steps !== 4'd2 || sta_a !== 3'd1) $display("FAIL c_to_b_end got s%0d sta%0d want s2 sta1", ifa.o_steps, sta_a); else pass_n++;
  endtask

  task automatic test_same_state();
    logic [11:0] seq; int nh, kend;
    load_a(3'd3);
    go(3'd3, 3, seq, nh, kend);
    chk_n++; if (kend != 0 || ifa.o_done !== 1'b1 || ifa.o_err !== 1'b0) $display("FAIL same_done got t%0d d%b e%b want t0 d1 e0", kend, ifa.o_done, ifa.o_err); else pass_n++;
    chk_n++; if (nh != 0 || ifa.o_steps !== 4'd0 || ifa.o_busy !== 1'b0) $display("FAIL same_quiet got h%0d s%0d b%b want 0 0 0", nh, ifa.o_steps, ifa.o_busy); else pass_n++;
  endtask

  task automatic test_mismatch();
    logic [11:0] seq; int nh, kend;
    load_a(3'd0);
    hold_a = 1'b1;
    go(3'd2, 4, seq, nh, kend);
    chk_n++; if (kend != 2 || ifa.o_err !== 1'b1 || ifa.o_done !== 1'b0) $display("FAIL mismatch_err got t%0d e%b d%b want t2 e1 d0", kend, ifa.o_err, ifa.o_done); else pass_n++;
    chk_n++; if (nh != 1 || ifa.o_steps !== 4'd1 || {ifa.o_x, ifa.o_y} !== 2'b00) $display("FAIL mismatch_end got h%0d s%0d xy%b want 1 1 00", nh, ifa.o_steps, {ifa.o_x, ifa.o_y}); else pass_n++;
    hold_a = 1'b0;
  endtask

  task automatic test_busy_start();
    int kend;
    logic saw_busy;
    load_a(3'd0);
    kend = -1;
    ifa.i_target = 3'd2; ifa.i_start = 1'b1; tick(); ifa.i_start = 1'b0;
    tick();
    ifa.i_start = 1'b1; ifa.i_target = 3'd1; tick(); ifa.i_start = 1'b0;
    saw_busy = ifa.o_busy;
    for (int k = 3; k <= 8; k++) begin
      tick();
      if (kend < 0 && (ifa.o_done | ifa.o_err)) kend = k;
    end
    chk_n++; if (saw_busy !== 1'b1 || kend != 6) $display("FAIL busy_ignore got b%b t%0d want b1 t6", saw_busy, kend); else pass_n++;
    chk_n++; if (ifa.o_done !== 1'b1 || ifa.o_steps !== 4'd3 || sta_a !== 3'd2) $display("FAIL busy_ignore_end got d%b s%0d sta%0d want d1 s3 sta2", ifa.o_done, ifa.o_steps, sta_a); else pass_n++;
  endtask

  task automatic test_reset_mid_run();
    load_a(3'd0);
    ifa.i_target = 3'd2; ifa.i_start = 1'b1; tick(); ifa.i_start = 1'b0;
    chk_n++; if ({ifa.o_x, ifa.o_busy} !== 2'b11) $display("FAIL drive_before_rst got %b want 11", {ifa.o_x, ifa.o_busy}); else pass_n++;
    #2 rst_n = 1'b0;
    #1;
    chk_n++; if ({ifa.o_x, ifa.o_y, ifa.o_busy, ifa.o_done, ifa.o_err} !== 5'b0 || ifa.o_steps !== 4'd0) $display("FAIL async_rst got %b s%0d want 00000 s0", {ifa.o_x, ifa.o_y, ifa.o_busy, ifa.o_done, ifa.o_err}, ifa.o_steps); else pass_n++;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk_n++; if ({ifa.o_busy, ifa.o_done, ifa.o_err} !== 3'b0 || sta_a !== 3'd0) $display("FAIL rst_unreported got %b sta%0d want 000 sta0", {ifa.o_busy, ifa.o_done, ifa.o_err}, sta_a); else pass_n++;
  endtask

  task automatic test_step_limit();
    logic [11:0] seq; int nh, kend;
    seq = '0; nh = 0; kend = -1;
    load_b(3'd4);
    ifb.i_target = 3'd0; ifb.i_start = 1'b1; tick(); ifb.i_start = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      if (ifb.o_x | ifb.o_y) begin seq = {seq[9:0], ifb.o_x, ifb.o_y}; nh++; end
      if (kend < 0 && (ifb.o_done | ifb.o_err)) kend = k;
    end
    chk_n++; if (kend != 4 || ifb.o_err !== 1'b1 || ifb.o_done !== 1'b0) $display("FAIL limit_err got t%0d e%b d%b want t4 e1 d0", kend, ifb.o_err, ifb.o_done); else pass_n++;
    chk_n++; if (nh != 2 || seq[3:0] !== 4'b1010 || ifb.o_steps !== 4'd2 || sta_b !== 3'd1) $display("FAIL limit_end got h%0d %b s%0d sta%0d want 2 1010 2 1", nh, seq[3:0], ifb.o_steps, sta_b); else pass_n++;
  endtask

  initial begin
    test_reset();
    test_a_to_c();
    test_a_to_f();
    test_from_c();
    test_same_state();
    test_mismatch();
    test_busy_start();
    test_reset_mid_run();
    test_step_limit();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
